ccl_labeler_p: RTL and testbench
================================

Name: ccl_labeler_p

Overview:
Parametrised next-generation connected-components first-pass labeler. It takes a raster stream of foreground bits plus the already-labelled A, B, C and D neighbours, and assigns provisional labels. Equivalences go onto ping-pong merge stacks, one bank per row parity, and are retired into an internal merge table. The block emits resolved labels with fixed latency. It sits between the neighbourhood line buffer and the feature-accumulation data table, and adds configurable width, stack depth, 4/8-connectivity, and saturation/overflow status.

Parameters:
LABEL_W, 8, label width; merge table has 2^LABEL_W entries; label 0 reserved for background.
MERGE_DEPTH, 16, entries per merge stack bank; power of two, >= 2.
CONN8, 1, 1 = 8-connectivity (A, B, C, D used); 0 = 4-connectivity (only B, D used; A and C forced to 0).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  pixel advance; when low all state holds
row_start  in  1  qualified by en; first pixel of a new row; toggles stack bank
fg  in  1  current pixel is foreground
A, B, C, D  in  LABEL_W each  neighbour labels (NW, N, NE, W)
label_out  out  LABEL_W  resolved label, 2 enabled cycles after input
label_valid  out  1  label_out corresponds to an accepted pixel
num_labels  out  LABEL_W  next label to allocate
label_exhausted  out  1  sticky: allocation saturated
merge_overflow  out  1  sticky: a merge was dropped on full stack
merge_pending  out  1  either stack bank non-empty

Behaviour:
- Reset (async): label_out=0, label_valid=0, num_labels=1, bank_sel=0, both stack pointers=0, label_exhausted=0, merge_overflow=0, pipeline registers 0. Merge table contents are not reset.
- en=0: no register, stack, table or counter changes. Outputs hold.
- Selection, combinational on the masked neighbours (N = set of nonzero used neighbours):
  - fg=0: background, label 0.
  - N empty: new label = num_labels. Write table[num_labels]=num_labels at this edge. Increment num_labels unless it equals 2^LABEL_W-1. When equal, assign it, set label_exhausted, do not increment. All later new pixels share that label.
  - All of N equal: copy that value.
  - Otherwise: merge. Label = min(N). Push {max(N), min(N)} to write bank (bank_sel). Assume at most one merge per pixel; more than two distinct labels still push only max/min.
- Stage 0 register (edge k): selected label, bg flag, valid=1.
- Stage 1 (edge k+1): label_out = bg ? 0 : table[stage0 label]; label_valid = stage0 valid. Latency is exactly 2 enabled edges.
- Table has one write port. New-label write has priority over pop write. Read uses write-first bypass: if the same edge writes the address being read, label_out takes the written data.
- Stacks: the write bank is bank_sel and the read bank is ~bank_sel. row_start && en toggles bank_sel at that edge; the push of that same pixel goes to the pre-toggle bank.
- Pop: one per enabled edge when the read bank is non-empty and there is no new-label write that edge. It writes table[top.max]=top.min. Push and pop in different banks at the same edge are both honoured.
- Push to a full bank: entry dropped, merge_overflow set, pointer unchanged.
- Entries left in a read bank when it becomes the write bank stay in place. New pushes stack on top, and those entries are popped after the next toggle.
- merge_pending = |ptr0 | |ptr1.
- Widths: min/max/compares are LABEL_W unsigned. Counter never wraps.

Test Plan:
- Reset, then en=1, fg=1, A..D=0 → 2 edges later label_out=1, label_valid=1; num_labels=2.
- CONN8=1; label 3 and label 5 exist; pixel fg=1, A=3, C=5 → label_out=3, merge_pending=1. After row_start and one idle pop cycle, pixel fg=1, B=5 → label_out=3, merge_pending=0.
- CONN8=0; fg=1, A=3, C=5, B=D=0 → new label (num_labels value) output, no push.
- LABEL_W=4; 16 isolated new pixels → labels 1..15, then 15 again. label_exhausted=1 after the 15th allocation; num_labels stays 15.
- MERGE_DEPTH=4; 5 merges within one row → merge_overflow=1; after row_start exactly 4 pops occur, then merge_pending=0.
- en held low 3 cycles mid-stream → outputs frozen, no pops. Assert reset while merge_pending=1 → all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/ccl_labeler_p.sv
// rtl/ccl_labeler_p.sv - connected-components first-pass labeler with ping-pong merge stacks
//
// Assigns provisional labels to a raster stream of foreground pixels from the
// already-labelled NW/N/NE/W neighbours. Equivalences are pushed onto one of two
// merge stacks (selected by row parity) and retired into a merge table that is
// used to resolve the label emitted two enabled cycles after the pixel.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   en                 pixel advance; all state holds when low
//   row_start          first pixel of a row; toggles the stack bank
//   fg                 current pixel is foreground
//   A, B, C, D         neighbour labels (NW, N, NE, W)
//   label_out          resolved label of the pixel accepted two enabled edges earlier
//   label_valid        label_out belongs to an accepted pixel
//   num_labels         next label to allocate
//   label_exhausted    sticky: allocation saturated at the last label
//   merge_overflow     sticky: a merge was dropped on a full stack
//   merge_pending      either stack bank holds entries

module ccl_labeler_p #(
    parameter int LABEL_W     = 8,
    parameter int MERGE_DEPTH = 16,
    parameter int CONN8       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               row_start,
    input  logic               fg,
    input  logic [LABEL_W-1:0] A,
    input  logic [LABEL_W-1:0] B,
    input  logic [LABEL_W-1:0] C,
    input  logic [LABEL_W-1:0] D,
    output logic [LABEL_W-1:0] label_out,
    output logic               label_valid,
    output logic [LABEL_W-1:0] num_labels,
    output logic               label_exhausted,
    output logic               merge_overflow,
    output logic               merge_pending
);

    localparam int AW      = $clog2(MERGE_DEPTH);
    localparam int PW      = AW + 1;
    localparam int NUM_ENT = 1 << LABEL_W;
    localparam logic [LABEL_W-1:0] LAST_LABEL = '1;

    logic [LABEL_W-1:0]   merge_tbl [NUM_ENT];
    logic [2*LABEL_W-1:0] stack_mem [2][MERGE_DEPTH];
    logic [PW-1:0]        ptr [2];
    logic                 bank_sel;

    logic [LABEL_W-1:0] s0_label;
    logic               s0_bg;
    logic               s0_valid;

    // In 4-connectivity the diagonal neighbours never contribute.
    logic [LABEL_W-1:0] nb [4];
    assign nb[0] = (CONN8 != 0) ? A : '0;
    assign nb[1] = B;
    assign nb[2] = (CONN8 != 0) ? C : '0;
    assign nb[3] = D;

    logic               nb_any;
    logic [LABEL_W-1:0] nb_min;
    logic [LABEL_W-1:0] nb_max;

    // Zero neighbours are background and are excluded from the min.
    always_comb begin
        nb_any = 1'b0;
        nb_min = '1;
        nb_max = '0;
        for (int i = 0; i < 4; i++) begin
            if (nb[i] != '0) begin
                nb_any = 1'b1;
                if (nb[i] < nb_min) nb_min = nb[i];
                if (nb[i] > nb_max) nb_max = nb[i];
            end
        end
    end

    logic               is_new;
    logic               is_merge;
    logic [LABEL_W-1:0] sel_label;

    assign is_new    = fg && !nb_any;
    assign is_merge  = fg && nb_any && (nb_min != nb_max);
    // min(N) is also the shared value when all neighbours agree.
    assign sel_label = !fg ? '0 : (!nb_any ? num_labels : nb_min);

    logic                 wb;
    logic                 rb;
    logic                 push_full;
    logic                 do_push;
    logic                 do_pop;
    logic [AW-1:0]        push_idx;
    logic [AW-1:0]        pop_idx;
    logic [2*LABEL_W-1:0] pop_top;

    assign wb        = bank_sel;
    assign rb        = ~bank_sel;
    assign push_full = (ptr[wb] == PW'(MERGE_DEPTH));
    assign do_push   = en && is_merge && !push_full;
    // A new-label write owns the single table port, so the pop waits.
    assign do_pop    = en && (ptr[rb] != '0) && !is_new;
    assign push_idx  = AW'(ptr[wb]);
    assign pop_idx   = AW'(ptr[rb] - PW'(1));
    assign pop_top   = stack_mem[rb][pop_idx];

    logic               tbl_we;
    logic [LABEL_W-1:0] tbl_wa;
    logic [LABEL_W-1:0] tbl_wd;
    logic [LABEL_W-1:0] rd_data;

    assign tbl_we  = en && (is_new || do_pop);
    assign tbl_wa  = is_new ? num_labels : pop_top[2*LABEL_W-1:LABEL_W];
    assign tbl_wd  = is_new ? num_labels : pop_top[LABEL_W-1:0];
    // Write-first: a same-edge write to the address being resolved wins.
    assign rd_data = (tbl_we && (tbl_wa == s0_label)) ? tbl_wd : merge_tbl[s0_label];

    always_ff @(posedge clk) begin
        if (tbl_we) merge_tbl[tbl_wa] <= tbl_wd;
        if (do_push) stack_mem[wb][push_idx] <= {nb_max, nb_min};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_label        <= '0;
            s0_bg           <= 1'b0;
            s0_valid        <= 1'b0;
            label_out       <= '0;
            label_valid     <= 1'b0;
            num_labels      <= LABEL_W'(1);
            label_exhausted <= 1'b0;
            merge_overflow  <= 1'b0;
            bank_sel        <= 1'b0;
            ptr[0]          <= '0;
            ptr[1]          <= '0;
        end else if (en) begin
            s0_label    <= sel_label;
            s0_bg       <= !fg;
            s0_valid    <= 1'b1;
            label_out   <= s0_bg ? '0 : rd_data;
            label_valid <= s0_valid;
            if (is_new) begin
                if (num_labels == LAST_LABEL) label_exhausted <= 1'b1;
                else                          num_labels      <= num_labels + LABEL_W'(1);
            end
            if (is_merge && push_full) merge_overflow <= 1'b1;
            // Push and pop always address different banks.
            if (do_push) ptr[wb] <= ptr[wb] + PW'(1);
            if (do_pop)  ptr[rb] <= ptr[rb] - PW'(1);
            if (row_start) bank_sel <= ~bank_sel;
        end
    end

    assign merge_pending = (ptr[0] != '0) || (ptr[1] != '0);

endmodule

// File: tb/tb_ccl_labeler_p.sv
// tb/tb_ccl_labeler_p.sv - self-checking bench for ccl_labeler_p (8- and 4-connectivity instances)

module tb_ccl_labeler_p;

    localparam int LW  = 4;
    localparam int MD  = 4;
    localparam int NT  = 1 << LW;
    localparam int TOP = NT - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          row_start = 1'b0;
    logic          fg = 1'b0;
    logic [LW-1:0] A = '0, B = '0, C = '0, D = '0;

    logic [LW-1:0] lo8, nl8, lo4, nl4;
    logic          lv8, ex8, ov8, pd8, lv4, ex4, ov4, pd4;

    ccl_labeler_p #(.LABEL_W(LW), .MERGE_DEPTH(MD), .CONN8(1)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .row_start(row_start), .fg(fg),
        .A(A), .B(B), .C(C), .D(D),
        .label_out(lo8), .label_valid(lv8), .num_labels(nl8),
        .label_exhausted(ex8), .merge_overflow(ov8), .merge_pending(pd8)
    );

    ccl_labeler_p #(.LABEL_W(LW), .MERGE_DEPTH(MD), .CONN8(0)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .row_start(row_start), .fg(fg),
        .A(A), .B(B), .C(C), .D(D),
        .label_out(lo4), .label_valid(lv4), .num_labels(nl4),
        .label_exhausted(ex4), .merge_overflow(ov4), .merge_pending(pd4)
    );

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    // Reference model; index 0 is the 8-connected instance, 1 the 4-connected one.
    int m_nl [2];
    bit m_exh [2];
    bit m_ovf [2];
    int m_bsel [2];
    int m_cnt [2][2];
    int m_smax [2][2][MD];
    int m_smin [2][2][MD];
    int m_tbl [2][NT];
    int m_s0_lab [2];
    bit m_s0_bg [2];
    bit m_s0_v [2];
    int m_lo [2];
    bit m_lv [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_nl[m] = 1; m_exh[m] = 0; m_ovf[m] = 0; m_bsel[m] = 0;
            m_cnt[m][0] = 0; m_cnt[m][1] = 0;
            m_s0_lab[m] = 0; m_s0_bg[m] = 0; m_s0_v[m] = 0;
            m_lo[m] = 0; m_lv[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        int v[4];
        int mn, mx, lab, wa, wd, wb, rb;
        bit any, neww, we;
        v[0] = (m == 0) ? int'(A) : 0;
        v[1] = int'(B);
        v[2] = (m == 0) ? int'(C) : 0;
        v[3] = int'(D);
        any = 0; mn = 1000; mx = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] != 0) begin
                any = 1;
                if (v[i] < mn) mn = v[i];
                if (v[i] > mx) mx = v[i];
            end
        end
        neww = 0; we = 0; wa = 0; wd = 0;
        if (!fg) lab = 0;
        else if (!any) begin
            lab = m_nl[m]; neww = 1; we = 1; wa = m_nl[m]; wd = m_nl[m];
            if (m_nl[m] == TOP) m_exh[m] = 1;
            else m_nl[m]++;
        end else lab = mn;
        wb = m_bsel[m]; rb = 1 - wb;
        if (fg && any && mn != mx) begin
            if (m_cnt[m][wb] == MD) m_ovf[m] = 1;
            else begin
                m_smax[m][wb][m_cnt[m][wb]] = mx;
                m_smin[m][wb][m_cnt[m][wb]] = mn;
                m_cnt[m][wb]++;
            end
        end
        if (!neww && m_cnt[m][rb] > 0) begin
            m_cnt[m][rb]--;
            we = 1; wa = m_smax[m][rb][m_cnt[m][rb]]; wd = m_smin[m][rb][m_cnt[m][rb]];
        end
        if (we) m_tbl[m][wa] = wd;
        m_lo[m] = m_s0_bg[m] ? 0 : m_tbl[m][m_s0_lab[m]];
        m_lv[m] = m_s0_v[m];
        m_s0_lab[m] = lab; m_s0_bg[m] = !fg; m_s0_v[m] = 1;
        if (row_start) m_bsel[m] = 1 - m_bsel[m];
    endtask

    task automatic cmp_one(input int m, input int lo, input bit lv, input int nl,
                           input bit ex, input bit ov, input bit pd);
        if (m_lv[m]) chk($sformatf("label_out[%0d]", m), lo, m_lo[m]);
        chk($sformatf("label_valid[%0d]", m), lv, m_lv[m]);
        chk($sformatf("num_labels[%0d]", m), nl, m_nl[m]);
        chk($sformatf("label_exhausted[%0d]", m), ex, m_exh[m]);
        chk($sformatf("merge_overflow[%0d]", m), ov, m_ovf[m]);
        chk($sformatf("merge_pending[%0d]", m), pd, (m_cnt[m][0] + m_cnt[m][1]) != 0);
    endtask

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            cmp_one(0, lo8, lv8, nl8, ex8, ov8, pd8);
            cmp_one(1, lo4, lv4, nl4, ex4, ov4, pd4);
        end
    end

    task automatic px(input bit e, input bit rs, input bit f, input int a, input int b,
                      input int c, input int d);
        en = e; row_start = rs; fg = f;
        A = LW'(a); B = LW'(b); C = LW'(c); D = LW'(d);
        @(posedge clk);
        #1;
        if (e) begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lo8"}, lo8, 0); chk({tag, "_lv8"}, lv8, 0); chk({tag, "_nl8"}, nl8, 1);
        chk({tag, "_ex8"}, ex8, 0); chk({tag, "_ov8"}, ov8, 0); chk({tag, "_pd8"}, pd8, 0);
        chk({tag, "_lo4"}, lo4, 0); chk({tag, "_nl4"}, nl4, 1); chk({tag, "_pd4"}, pd4, 0);
    endtask

    function automatic int nb_lim();
        int l, x;
        l = 1000;
        for (int m = 0; m < 2; m++) begin
            x = m_exh[m] ? m_nl[m] : m_nl[m] - 1;
            if (x < l) l = x;
        end
        return l;
    endfunction

    function automatic int rnd_nb(input int l);
        if (l <= 0 || $urandom_range(0, 1) == 0) return 0;
        return int'($urandom_range(1, l));
    endfunction

    initial begin
        #1;
        reset = 1'b1;
        model_reset();
        #10;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        run_chk = 1'b1;

        // First isolated pixel gets label 1 two edges later.
        px(1, 0, 1, 0, 0, 0, 0);
        px(1, 0, 0, 0, 0, 0, 0);
        chk("first_lo8", lo8, 1); chk("first_lv8", lv8, 1); chk("first_nl8", nl8, 2);
        chk("first_lo4", lo4, 1);

        // Labels 2..5, then A=3/C=5 merges in 8-conn, allocates 6 in 4-conn.
        repeat (4) px(1, 0, 1, 0, 0, 0, 0);
        px(1, 0, 1, 3, 0, 5, 0);
        px(1, 0, 0, 0, 0, 0, 0);
        chk("merge_lo8", lo8, 3); chk("merge_pd8", pd8, 1);
        chk("conn4_lo4", lo4, 6); chk("conn4_pd4", pd4, 0); chk("conn4_nl4", nl4, 7);
        px(1, 1, 0, 0, 0, 0, 0);
        px(1, 0, 0, 0, 0, 0, 0);
        chk("pop_pd8", pd8, 0);
        px(1, 0, 1, 0, 5, 0, 0);
        px(1, 0, 0, 0, 0, 0, 0);
        chk("resolved_lo8", lo8, 3); chk("resolved_lo4", lo4, 5);

        // Saturation: 16 isolated pixels give 1..15 then 15 again.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            px(1, 0, i <= 16, 0, 0, 0, 0);
            if (i >= 2) chk($sformatf("sat_lo8_%0d", i), lo8, (i - 1 > TOP) ? TOP : i - 1);
            if (i == 14) chk("sat_ex8_before", ex8, 0);
            if (i == 15) chk("sat_ex8_after", ex8, 1);
        end
        chk("sat_nl8", nl8, TOP); chk("sat_nl4", nl4, TOP); chk("sat_ex4", ex4, 1);

        // Five merges in one row overflow a 4-deep bank; exactly four pops follow.
        for (int k = 0; k < 5; k++) px(1, 0, 1, 2 * k + 1, 0, 2 * k + 2, 0);
        chk("ovf_ov8", ov8, 1); chk("ovf_ov4", ov4, 0); chk("ovf_pd8", pd8, 1);
        px(1, 1, 0, 0, 0, 0, 0);
        chk("ovf_toggle_pd8", pd8, 1);
        for (int k = 1; k <= 4; k++) begin
            px(1, 0, 0, 0, 0, 0, 0);
            chk($sformatf("ovf_pop%0d_pd8", k), pd8, k < 4);
        end

        // Freeze with a pop waiting.
        px(1, 0, 1, 1, 0, 3, 0);
        px(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            px(0, 1, 1, 0, 0, 0, 0);
            chk("freeze_pd8", pd8, 1); chk("freeze_lo8", lo8, 1); chk("freeze_lo4", lo4, TOP);
            chk("freeze_nl8", nl8, TOP);
        end
        px(1, 0, 0, 0, 0, 0, 0);
        chk("thaw_pd8", pd8, 0);

        // Asynchronous reset while a merge is pending.
        px(1, 0, 1, 1, 0, 3, 0);
        chk("pre_rst_pd8", pd8, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int it = 0; it < 3000; it++) begin
            int l;
            if (it % 200 == 199) do_reset();
            l = nb_lim();
            px($urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
               rnd_nb(l), rnd_nb(l), rnd_nb(l), rnd_nb(l));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
